// File: rtl/eseram_pkg.sv
// Shared types and constants for the ESE-RAM SD data-window transfer controller.
package eseram_pkg;

  // Transfer sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_STROBE     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_CAPTURE    = 3'd4
  } xfer_state_e;

  // One-deep request queue entry.
  typedef struct packed {
    logic       valid;
    logic       wr;
    logic [7:0] data;
  } pend_slot_t;

  // Byte clocked out on MOSI while receiving.
  localparam logic [7:0] SD_DUMMY_BYTE = 8'hFF;

  localparam pend_slot_t PEND_EMPTY = '{valid: 1'b0, wr: 1'b0, data: 8'h00};

endpackage

// File: rtl/eseram_sd_watchdog.sv
// Saturating 16-bit cycle timer: cleared by clear_i, counts while run_i,
// and flags expiry on the cycle the count reaches LIMIT-1 while running.
module eseram_sd_watchdog #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        run_i,
  output logic [15:0] count_o,
  output logic        expire_o
);

  logic [15:0] count_q, count_d;

  // Next count: clear wins, then saturating increment while running.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 16'd0;
    end else if (run_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = run_i && ({16'd0, count_q} >= 32'(LIMIT - 1));

endmodule

// File: rtl/eseram_sd_xfer_ctrl.sv
// Sequences single-byte SPI transfers for the mapper's SD data window with a
// one-deep request slot, a read-ahead byte, CPU wait generation and a watchdog.
//
// Engine handshake: sd_tx / sd_rx are one-cycle strobes issued only in STROBE,
// never together; the engine may raise sd_busy some cycles later and the byte
// on sd_data_from is taken once sd_busy falls (or after START_CYCLES if the
// engine never signals busy, i.e. it completed instantly).
module eseram_sd_xfer_ctrl
  import eseram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned START_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_wait,
  input  logic       err_clr,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic [7:0] sd_data_to,
  output logic       sd_tx,
  output logic       sd_rx,
  input  logic [7:0] sd_data_from,
  input  logic       sd_busy
);

  xfer_state_e state_q, state_d;
  pend_slot_t  pend_q, pend_d;
  logic        cur_wr_q, cur_wr_d;
  logic [7:0]  cur_data_q, cur_data_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_to_q, err_to_d;
  logic        err_ov_q, err_ov_d;

  logic [15:0] wd_count;
  logic        wd_expire;
  logic        start_elapsed;
  logic        abort;
  logic        direct;

  eseram_sd_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q == ST_STROBE),
    .run_i    ((state_q == ST_WAIT_START) || (state_q == ST_WAIT_DONE)),
    .count_o  (wd_count),
    .expire_o (wd_expire)
  );

  assign start_elapsed = ({16'd0, wd_count} >= 32'(START_CYCLES - 1));

  // The slot frees at the CAPTURE edge, so the CPU is released during CAPTURE.
  assign cpu_wait = pend_q.valid && (state_q != ST_IDLE) && (state_q != ST_CAPTURE);

  // Only an idle controller with nothing queued takes a request straight to STROBE.
  assign direct = (state_q == ST_IDLE) && !pend_q.valid;

  // Next-state, slot, read-ahead and error flag logic.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cur_wr_d   = cur_wr_q;
    cur_data_d = cur_data_q;
    rdata_d    = rdata_q;
    err_to_d   = err_to_q & ~err_clr;
    err_ov_d   = err_ov_q & ~err_clr;
    abort      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q.valid) begin
          state_d      = ST_STROBE;
          cur_wr_d     = pend_q.wr;
          cur_data_d   = pend_q.data;
          pend_d.valid = 1'b0;
        end else if (cpu_req) begin
          state_d    = ST_STROBE;
          cur_wr_d   = cpu_wr;
          cur_data_d = cpu_wdata;
        end
      end
      ST_STROBE: begin
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (wd_expire) begin
          abort = 1'b1;
        end else if (sd_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (start_elapsed) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_WAIT_DONE: begin
        if (wd_expire) begin
          abort = 1'b1;
        end else if (!sd_busy) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rdata_d = sd_data_from;
        if (pend_q.valid) begin
          state_d      = ST_STROBE;
          cur_wr_d     = pend_q.wr;
          cur_data_d   = pend_q.data;
          pend_d.valid = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d  = ST_IDLE;
      rdata_d  = SD_DUMMY_BYTE;
      err_to_d = 1'b1;
      pend_d   = PEND_EMPTY;
    end

    // Requests not taken directly land in the slot, which is always free here
    // unless cpu_wait is high (then the request is lost and flagged).
    if (cpu_req) begin
      if (cpu_wait) begin
        err_ov_d = 1'b1;
      end else if (!direct) begin
        pend_d = '{valid: 1'b1, wr: cpu_wr, data: cpu_wdata};
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_q     <= PEND_EMPTY;
      cur_wr_q   <= 1'b0;
      cur_data_q <= SD_DUMMY_BYTE;
      rdata_q    <= SD_DUMMY_BYTE;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cur_wr_q   <= cur_wr_d;
      cur_data_q <= cur_data_d;
      rdata_q    <= rdata_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
    end
  end

  assign sd_tx       = (state_q == ST_STROBE) && cur_wr_q;
  assign sd_rx       = (state_q == ST_STROBE) && !cur_wr_q;
  assign sd_data_to  = ((state_q == ST_STROBE) && cur_wr_q) ? cur_data_q : SD_DUMMY_BYTE;
  assign cpu_rdata   = rdata_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule
